// File: rtl/button_reader.sv
// Push-button input path: per-button synchroniser and debouncer lanes feeding a
// single-entry press/release event register with a sticky drop flag.

module button_reader_lane #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_i,
    output logic level_o,
    output logic chg_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic          meta_q, sync_q, level_q;
    logic [CW-1:0] cnt_q;
    logic          differ, expire;

    assign differ  = (sync_q != level_q);
    assign expire  = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign level_o = level_q;
    assign chg_o   = expire;

    // Polarity is folded in ahead of the flops so every state bit resets to "not pressed".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= raw_i ^ INV;
            sync_q <= meta_q;
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

module button_reader #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [2:0]       evt_idx,
    output logic             evt_press,
    input  logic             evt_ack,
    output logic             evt_overflow,
    input  logic             ovf_clr
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q;
    logic [2:0]       idx_q;
    logic             press_q, ovf_q;
    logic [N_BTN-1:0] chg;
    logic [2:0]       sel_idx;
    logic             sel_press, any_evt, multi_evt, load, drop;
    logic [N_BTN-1:0] rest;

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        button_reader_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .raw_i   (btn_raw[g]),
            .level_o (btn_level[g]),
            .chg_o   (chg[g])
        );
    end

    // Lowest-index change wins; a lane's new level is the inverse of its current one.
    always_comb begin
        sel_idx   = '0;
        sel_press = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (chg[i]) begin
                sel_idx   = 3'(i);
                sel_press = ~btn_level[i];
            end
        end
        any_evt   = |chg;
        rest      = chg & ~(N_BTN'(1) << sel_idx);
        multi_evt = |rest;
        load      = any_evt && ((state_q == EMPTY) || evt_ack);
        drop      = ((state_q == FULL) && !evt_ack) ? any_evt : multi_evt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            press_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (any_evt) state_q <= FULL;
                FULL:  if (evt_ack && !any_evt) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (load) begin
                idx_q   <= sel_idx;
                press_q <= sel_press;
            end
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign evt_valid    = (state_q == FULL);
    assign evt_idx      = idx_q;
    assign evt_press    = press_q;
    assign evt_overflow = ovf_q;
endmodule

// File: tb/tb_button_reader.sv
// Directed bench: expected events go into a queue, a negedge monitor pops and
// compares each newly presented event; level/flag checks are made inline.

module tb_button_reader;
    localparam int N  = 5;
    localparam int DC = 4;

    typedef struct packed {
        logic [2:0] idx;
        logic       press;
    } ev_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic         evt_valid, evt_press, evt_ack, evt_overflow, ovf_clr;
    logic [2:0]   evt_idx;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    button_reader #(.N_BTN(N), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .evt_valid    (evt_valid),
        .evt_idx      (evt_idx),
        .evt_press    (evt_press),
        .evt_ack      (evt_ack),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] idx, input logic press);
        ev_t e;
        e.idx   = idx;
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic ack_once();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
    endtask

    // A new event is on the bus when valid rises, or stays high across an acked edge.
    logic vprev = 1'b0, aprev = 1'b0;
    always @(negedge clk) begin
        if (evt_valid && (!vprev || aprev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got idx=%0d press=%0b expected none", evt_idx, evt_press);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (evt_idx !== e.idx || evt_press !== e.press) begin
                    errors++;
                    $display("FAIL event: got idx=%0d press=%0b expected idx=%0d press=%0b",
                             evt_idx, evt_press, e.idx, e.press);
                end
            end
        end
        vprev = evt_valid;
        aprev = evt_ack;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn    = 1'b0;
        btn_raw = '1;
        evt_ack = 1'b0;
        ovf_clr = 1'b0;
        tick(3);
        check("rst_level", btn_level, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_idx", evt_idx, 0);
        check("rst_ovf", evt_overflow, 0);
        rstn = 1'b1;
        tick(3);

        // Clean press of button 2: level after exactly DC+2 edges.
        expect_ev(3'd2, 1'b1);
        btn_raw[2] = 1'b0;
        tick(DC + 1);
        check("t1_level_early", btn_level[2], 0);
        check("t1_valid_early", evt_valid, 0);
        tick();
        check("t1_level", btn_level[2], 1);
        check("t1_valid", evt_valid, 1);
        ack_once();
        check("t1_valid_after_ack", evt_valid, 0);
        expect_ev(3'd2, 1'b0);
        btn_raw[2] = 1'b1;
        tick(DC + 2);
        check("t1_release_level", btn_level[2], 0);
        ack_once();

        // Bounce on button 0: only the final stable hold produces one press.
        expect_ev(3'd0, 1'b1);
        btn_raw[0] = 1'b0; tick(2);
        btn_raw[0] = 1'b1; tick(2);
        btn_raw[0] = 1'b0; tick(2);
        btn_raw[0] = 1'b1; tick(2);
        btn_raw[0] = 1'b0;
        tick(DC + 1);
        check("t2_no_event_bounce", evt_valid, 0);
        check("t2_level_early", btn_level[0], 0);
        tick();
        check("t2_level", btn_level[0], 1);
        check("t2_valid", evt_valid, 1);
        ack_once();
        expect_ev(3'd0, 1'b0);
        btn_raw[0] = 1'b1;
        tick(DC + 2);
        ack_once();

        // Unacked press then release on button 1: release dropped, old event kept.
        expect_ev(3'd1, 1'b1);
        btn_raw[1] = 1'b0;
        tick(DC + 2);
        btn_raw[1] = 1'b1;
        tick(DC + 2);
        check("t3_level", btn_level[1], 0);
        check("t3_valid", evt_valid, 1);
        check("t3_idx_kept", evt_idx, 1);
        check("t3_press_kept", evt_press, 1);
        check("t3_ovf", evt_overflow, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t3_ovf_clr", evt_overflow, 0);
        ack_once();
        check("t3_valid_after_ack", evt_valid, 0);

        // Ack coinciding with a new release event on button 3.
        expect_ev(3'd3, 1'b1);
        btn_raw[3] = 1'b0;
        tick(DC + 2);
        expect_ev(3'd3, 1'b0);
        btn_raw[3] = 1'b1;
        tick(DC + 1);
        evt_ack = 1'b1; tick(); evt_ack = 1'b0;
        check("t4_valid", evt_valid, 1);
        check("t4_idx", evt_idx, 3);
        check("t4_press", evt_press, 0);
        check("t4_ovf", evt_overflow, 0);
        ack_once();

        // Buttons 1 and 4 on the same edge: lowest index wins, the other overflows.
        expect_ev(3'd1, 1'b1);
        btn_raw[1] = 1'b0;
        btn_raw[4] = 1'b0;
        tick(DC + 2);
        check("t5_level", btn_level, 5'b10010);
        check("t5_idx", evt_idx, 1);
        check("t5_ovf", evt_overflow, 1);
        ack_once();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Async reset with an event pending and a count in flight.
        expect_ev(3'd4, 1'b0);
        btn_raw[4] = 1'b1;
        tick(DC + 2);
        check("t6_pending", evt_valid, 1);
        btn_raw[2] = 1'b0;
        tick(4);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_level", btn_level, 0);
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_idx", evt_idx, 0);
        check("t6_rst_press", evt_press, 0);
        check("t6_rst_ovf", evt_overflow, 0);
        tick(2);
        expect_ev(3'd1, 1'b1);
        rstn = 1'b1;
        tick(DC + 1);
        check("t6_no_early_event", evt_valid, 0);
        tick();
        check("t6_level_held", btn_level, 5'b00110);
        check("t6_valid", evt_valid, 1);
        check("t6_ovf", evt_overflow, 1);
        ack_once();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
